// File: rtl/branch_pkg.sv
// branch_pkg: shared types and constants for EX-stage branch redirect control
package branch_pkg;

    typedef enum logic {IDLE, PEND} state_t;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_type_t;

    localparam logic [1:0] IALIGN_MASK = 2'b11;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk)
        count <= rst ? '0 : (inc && !(&count)) ? count + 1'b1 : count;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: resolves EX-stage control flow, redirects fetch, flushes wrong path
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             fetch_ready,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misalign_exc,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    state_t          state;
    logic [XLEN-1:0] pend_pc;
    logic            res, mis, fire, idle, br_inc;

    assign idle   = state == IDLE;
    assign res    = ex_valid & (ex_is_jump | (ex_is_branch & br_taken));
    assign mis    = res & |(ex_target[1:0] & IALIGN_MASK);
    assign fire   = res & ~mis;
    assign br_inc = idle & ex_valid & ex_is_branch & ~ex_is_jump;

    // PEND ignores EX entirely: only bubbles can sit there while fetch is busy
    assign redirect_valid = idle ? fire : 1'b1;
    assign redirect_pc    = idle ? (fire ? ex_target : '0) : pend_pc;
    assign flush_if_id    = idle ? res : 1'b1;
    assign flush_id_ex    = idle ? res : 1'b1;
    assign busy           = ~idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pend_pc      <= '0;
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= idle & mis;
            if (idle && fire && !fetch_ready) begin
                state   <= PEND;
                pend_pc <= ex_target;
            end else if (!idle && fetch_ready) begin
                state <= IDLE;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_inc),
        .count (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_inc & br_taken),
        .count (taken_cnt)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed vectors with a per-cycle expected-output scoreboard
module tb_branch_redirect_ctrl;

    typedef struct packed {
        logic        rv;
        logic [31:0] pc;
        logic        fi;
        logic        fe;
        logic        mis;
        logic        busy;
        logic [3:0]  bc;
        logic [3:0]  tc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0, br_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        fetch_ready = 1'b0;
    logic        redirect_valid, flush_if_id, flush_id_ex, misalign_exc, busy;
    logic [31:0] redirect_pc;
    logic [3:0]  branch_cnt, taken_cnt;

    exp_t  exp_q[$];
    string name_q[$];
    logic  chk_q[$];
    int    checks = 0;
    int    errors = 0;

    branch_redirect_ctrl #(.XLEN(32), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .br_taken       (br_taken),
        .ex_target      (ex_target),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .misalign_exc   (misalign_exc),
        .busy           (busy),
        .branch_cnt     (branch_cnt),
        .taken_cnt      (taken_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue the outputs expected in that same cycle
    task automatic step(input string nm, input logic r, v, b, j, t, input logic [31:0] tgt,
                        input logic fr, input logic chk, input logic erv, input logic [31:0] epc,
                        input logic ef, input logic em, input logic eb,
                        input logic [3:0] ebc, input logic [3:0] etc_);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ex_valid = v; ex_is_branch = b; ex_is_jump = j; br_taken = t;
        ex_target = tgt; fetch_ready = fr;
        e = '{rv: erv, pc: epc, fi: ef, fe: ef, mis: em, busy: eb, bc: ebc, tc: etc_};
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_q.push_back(chk);
    endtask

    task automatic idle(input string nm, input logic [3:0] ebc, input logic [3:0] etc_,
                        input logic em);
        step(nm, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0, 32'h0, 0, em, 0, ebc, etc_);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e, a;
            string n;
            logic  c;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            c = chk_q.pop_front();
            a = '{rv: redirect_valid, pc: redirect_pc, fi: flush_if_id, fe: flush_id_ex,
                  mis: misalign_exc, busy: busy, bc: branch_cnt, tc: taken_cnt};
            if (c) begin
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got rv=%b pc=%h fi=%b fe=%b mis=%b busy=%b bc=%h tc=%h, expected rv=%b pc=%h fi=%b fe=%b mis=%b busy=%b bc=%h tc=%h",
                             n, a.rv, a.pc, a.fi, a.fe, a.mis, a.busy, a.bc, a.tc,
                             e.rv, e.pc, e.fi, e.fe, e.mis, e.busy, e.bc, e.tc);
                end
            end
        end
    end

    initial begin
        step("reset_cycle", 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 4'h0, 4'h0);
        idle("reset_state", 4'h0, 4'h0, 0);
        // taken BEQ, zero-latency accept
        step("beq_taken", 0, 1, 1, 0, 1, 32'h100, 1, 1, 1, 32'h100, 1, 0, 0, 4'h0, 4'h0);
        idle("after_beq", 4'h1, 4'h1, 0);
        // not-taken branch
        step("not_taken", 0, 1, 1, 0, 0, 32'h200, 1, 1, 0, 32'h0, 0, 0, 0, 4'h1, 4'h1);
        idle("after_nt", 4'h2, 4'h1, 0);
        // JAL with busy fetch; a stray branch in PEND must be ignored
        step("jal_resolve", 0, 1, 0, 1, 0, 32'h2000, 0, 1, 1, 32'h2000, 1, 0, 0, 4'h2, 4'h1);
        step("pend_1", 0, 0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h2000, 1, 0, 1, 4'h2, 4'h1);
        step("pend_stray", 0, 1, 1, 0, 1, 32'h300, 0, 1, 1, 32'h2000, 1, 0, 1, 4'h2, 4'h1);
        step("pend_accept", 0, 0, 0, 0, 0, 32'h0, 1, 1, 1, 32'h2000, 1, 0, 1, 4'h2, 4'h1);
        idle("after_pend", 4'h2, 4'h1, 0);
        // misaligned taken branch
        step("mis_branch", 0, 1, 1, 0, 1, 32'h102, 1, 1, 0, 32'h0, 1, 0, 0, 4'h2, 4'h1);
        idle("mis_pulse", 4'h3, 4'h2, 1);
        idle("mis_clear", 4'h3, 4'h2, 0);
        // misaligned jump while fetch busy: no PEND entry
        step("mis_jump", 0, 1, 0, 1, 0, 32'h3, 0, 1, 0, 32'h0, 1, 0, 0, 4'h3, 4'h2);
        step("mis_jump_pulse", 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 4'h3, 4'h2);
        // aligned jump, zero latency
        step("jal_fast", 0, 1, 0, 1, 1, 32'h4, 1, 1, 1, 32'h4, 1, 0, 0, 4'h3, 4'h2);
        idle("after_jal_fast", 4'h3, 4'h2, 0);
        // reset while a redirect is pending
        step("pend40_resolve", 0, 1, 1, 0, 1, 32'h40, 0, 1, 1, 32'h40, 1, 0, 0, 4'h3, 4'h2);
        step("pend40_hold", 0, 0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h40, 1, 0, 1, 4'h4, 4'h3);
        step("pend40_rst", 1, 0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h40, 1, 0, 1, 4'h4, 4'h3);
        idle("after_rst", 4'h0, 4'h0, 0);
        // saturation: 17 taken branches into 4-bit counters
        for (int i = 0; i < 17; i++)
            step("sat", 0, 1, 1, 0, 1, 32'h100, 1, 1, 1, 32'h100, 1, 0, 0,
                 (i > 15) ? 4'hF : 4'(i), (i > 15) ? 4'hF : 4'(i));
        step("sat_nt", 0, 1, 1, 0, 0, 32'h100, 1, 1, 0, 32'h0, 0, 0, 0, 4'hF, 4'hF);
        idle("sat_final", 4'hF, 4'hF, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
